// File: rtl/memory_stage.sv
// Memory pipeline stage: EX/MM latch, word load/store with bounded wait, MM/WB latch.
// Latency: one cycle EX->MM and one cycle MM->WB; memory waits add one cycle per wait state.
// Backpressure: mm_stall holds upstream and the EX/MM latch while an access waits for ack.
module memory_stage #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic [1:0]  ex_mem_op,
  input  logic        ex_wb_en,
  input  logic [1:0]  ex_wb_kind,
  input  logic [4:0]  ex_dst,
  input  logic        result_P,
  input  logic [31:0] result_I,
  input  logic [31:0] result_F,
  input  logic [31:0] Wdata,
  output logic        mm_stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        pval_mm,
  output logic [31:0] rval_mm,
  output logic [31:0] fval_mm,
  output logic        wb_valid,
  output logic        wb_en,
  output logic [1:0]  wb_kind,
  output logic [4:0]  wb_dst,
  output logic [31:0] rval_wb,
  output logic        mem_err
);

  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_STORE = 2'b10;
  localparam logic [1:0] KIND_P   = 2'b00;
  localparam logic [1:0] KIND_I   = 2'b01;
  localparam logic [1:0] KIND_F   = 2'b10;
  localparam logic [7:0] TMO      = 8'(TIMEOUT);

  typedef enum logic {ST_RUN, ST_WAIT} state_t;

  state_t      state;
  logic [7:0]  wait_cnt;

  // EX/MM latch contents
  logic        mm_valid;
  logic [1:0]  mm_op;
  logic        mm_wb_en;
  logic [1:0]  mm_kind;
  logic [4:0]  mm_dst;
  logic        mm_p;
  logic [31:0] mm_i;
  logic [31:0] mm_f;
  logic [31:0] mm_wdata;

  logic        is_load;
  logic        is_store;
  logic        is_mem;
  logic        aligned;
  logic        in_wait;
  logic        misalign;
  logic        tmo_hit;
  logic        complete;
  logic        wb_en_nxt;
  logic [31:0] rval_nxt;

  // Decode of the instruction sitting in the EX/MM latch
  always_comb begin
    is_load  = mm_valid && (mm_op == OP_LOAD);
    is_store = mm_valid && (mm_op == OP_STORE);
    is_mem   = is_load || is_store;
    aligned  = (mm_i[1:0] == 2'b00);
    in_wait  = (state == ST_WAIT);
    misalign = (state == ST_RUN) && is_mem && !aligned;
    // The ack is checked first so an ack on the last allowed cycle still succeeds.
    tmo_hit  = in_wait && !dmem_ack && (wait_cnt == TMO);
  end

  // Request port and stall; the request drops with the latch/FSM on reset
  always_comb begin
    dmem_req   = ((state == ST_RUN) && is_mem && aligned) || in_wait;
    dmem_we    = dmem_req && is_store;
    dmem_addr  = dmem_req ? mm_i : 32'h0;
    dmem_wdata = dmem_req ? mm_wdata : 32'h0;
    mm_stall   = ((state == ST_RUN) && is_mem && aligned && !dmem_ack) ||
                 (in_wait && !dmem_ack && (wait_cnt != TMO));
    // Any valid instruction that is not stalled leaves the stage this cycle.
    complete   = mm_valid && !mm_stall;
  end

  // Write-back value selection; failed or store accesses never write a register
  always_comb begin
    wb_en_nxt = mm_wb_en && !is_store && !misalign && !tmo_hit;
    if (is_load) begin
      rval_nxt = dmem_rdata;
    end else begin
      case (mm_kind)
        KIND_P:  rval_nxt = {31'b0, mm_p};
        KIND_I:  rval_nxt = mm_i;
        KIND_F:  rval_nxt = mm_f;
        default: rval_nxt = mm_i;
      endcase
    end
  end

  // EX/MM latch: loads every non-stalled cycle, bubbles included
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mm_valid <= 1'b0;
      mm_op    <= 2'b00;
      mm_wb_en <= 1'b0;
      mm_kind  <= 2'b00;
      mm_dst   <= 5'd0;
      mm_p     <= 1'b0;
      mm_i     <= 32'h0;
      mm_f     <= 32'h0;
      mm_wdata <= 32'h0;
    end else if (!mm_stall) begin
      mm_valid <= ex_valid;
      mm_op    <= ex_mem_op;
      mm_wb_en <= ex_wb_en;
      mm_kind  <= ex_wb_kind;
      mm_dst   <= ex_dst;
      mm_p     <= result_P;
      mm_i     <= result_I;
      mm_f     <= result_F;
      mm_wdata <= Wdata;
    end
  end

  // Access FSM with wait counter and sticky error flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_RUN;
      wait_cnt <= 8'd0;
      mem_err  <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          if (misalign) begin
            mem_err <= 1'b1;
          end
          if (is_mem && aligned && !dmem_ack) begin
            state    <= ST_WAIT;
            wait_cnt <= 8'd1;
          end
        end
        ST_WAIT: begin
          if (dmem_ack) begin
            state    <= ST_RUN;
            wait_cnt <= 8'd0;
          end else if (wait_cnt == TMO) begin
            state    <= ST_RUN;
            wait_cnt <= 8'd0;
            mem_err  <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: begin
          state    <= ST_RUN;
          wait_cnt <= 8'd0;
        end
      endcase
    end
  end

  // MM/WB latch: valid only on completion; the value fields hold otherwise
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_valid <= 1'b0;
      wb_en    <= 1'b0;
      wb_kind  <= 2'b00;
      wb_dst   <= 5'd0;
      rval_wb  <= 32'h0;
    end else begin
      wb_valid <= complete;
      wb_en    <= complete && wb_en_nxt;
      if (complete) begin
        wb_kind <= mm_kind;
        wb_dst  <= mm_dst;
        rval_wb <= rval_nxt;
      end
    end
  end

  // Forwarding taps on the EX/MM latch (rval_mm is the address for memory ops)
  always_comb begin
    pval_mm = mm_p;
    rval_mm = mm_i;
    fval_mm = mm_f;
  end

endmodule

// File: tb/tb_memory_stage.sv
// Scoreboard bench for memory_stage: directed vectors, responder with programmable ack delay.
// Latency: expected write-backs are queued at issue and popped when wb_valid appears.
// Backpressure: the issue task holds EX inputs while mm_stall is high.
module tb_memory_stage;

  localparam logic [1:0] OP_NONE  = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_STORE = 2'b10;
  localparam logic [1:0] OP_RSVD  = 2'b11;
  localparam logic [1:0] K_P = 2'b00;
  localparam logic [1:0] K_I = 2'b01;
  localparam logic [1:0] K_F = 2'b10;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic [1:0]  ex_mem_op;
  logic        ex_wb_en;
  logic [1:0]  ex_wb_kind;
  logic [4:0]  ex_dst;
  logic        result_P;
  logic [31:0] result_I;
  logic [31:0] result_F;
  logic [31:0] Wdata;
  logic        mm_stall;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        pval_mm;
  logic [31:0] rval_mm;
  logic [31:0] fval_mm;
  logic        wb_valid;
  logic        wb_en;
  logic [1:0]  wb_kind;
  logic [4:0]  wb_dst;
  logic [31:0] rval_wb;
  logic        mem_err;

  memory_stage #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_mem_op(ex_mem_op), .ex_wb_en(ex_wb_en),
    .ex_wb_kind(ex_wb_kind), .ex_dst(ex_dst),
    .result_P(result_P), .result_I(result_I), .result_F(result_F), .Wdata(Wdata),
    .mm_stall(mm_stall),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .pval_mm(pval_mm), .rval_mm(rval_mm), .fval_mm(fval_mm),
    .wb_valid(wb_valid), .wb_en(wb_en), .wb_kind(wb_kind), .wb_dst(wb_dst),
    .rval_wb(rval_wb), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  dst;
    logic        en;
    logic [1:0]  kind;
    logic [31:0] rval;
    logic        chk_rval;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // responder controls and observation counters
  int          ack_lat   = 0;
  int          req_seen  = 0;
  logic        force_ack = 1'b0;
  logic [31:0] rd_val    = 32'h0;
  int          stall_cnt = 0;
  int          req_cnt   = 0;
  int          we_cnt    = 0;
  int          addr_bad  = 0;
  logic [31:0] last_wdata = 32'h0;
  logic        prev_req  = 1'b0;
  logic [31:0] prev_addr = 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_counts();
    stall_cnt = 0;
    req_cnt   = 0;
    we_cnt    = 0;
    addr_bad  = 0;
  endtask

  // Memory model: ack after ack_lat request cycles (negative = never)
  always @(negedge clk) begin
    if (dmem_req === 1'b1) begin
      if (ack_lat >= 0 && req_seen == ack_lat) begin
        dmem_ack   = 1'b1;
        dmem_rdata = rd_val;
        req_seen   = 0;
      end else begin
        dmem_ack = force_ack;
        req_seen++;
      end
    end else begin
      dmem_ack = force_ack;
      req_seen = 0;
    end
  end

  // Per-cycle observation of request/stall, sampled mid low phase
  always begin
    @(negedge clk);
    #2;
    if (mm_stall === 1'b1) stall_cnt++;
    if (dmem_req === 1'b1) begin
      req_cnt++;
      if (prev_req && dmem_addr !== prev_addr) addr_bad++;
      if (dmem_we === 1'b1) begin
        we_cnt++;
        last_wdata = dmem_wdata;
      end
    end
    prev_req  = (dmem_req === 1'b1);
    prev_addr = dmem_addr;
  end

  // Scoreboard monitor: every wb_valid pops one expected entry
  always begin
    @(posedge clk);
    #1;
    if (wb_valid === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL wb_unexpected: got wb_valid=1 dst=%0d expected no write-back", wb_dst);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("wb_dst", 32'(wb_dst), 32'(e.dst));
        chk("wb_en", 32'(wb_en), 32'(e.en));
        chk("wb_kind", 32'(wb_kind), 32'(e.kind));
        if (e.chk_rval) chk("rval_wb", rval_wb, e.rval);
      end
    end
  end

  // Present one EX slot and hold it until the stage accepts it
  task automatic issue(input logic v, input logic [1:0] op, input logic en,
                       input logic [1:0] kind, input logic [4:0] dst, input logic p,
                       input logic [31:0] ri, input logic [31:0] rf, input logic [31:0] wd,
                       input logic push, input logic exp_en, input logic [31:0] exp_rval,
                       input logic chk_rval);
    int guard;
    @(negedge clk);
    ex_valid   = v;
    ex_mem_op  = op;
    ex_wb_en   = en;
    ex_wb_kind = kind;
    ex_dst     = dst;
    result_P   = p;
    result_I   = ri;
    result_F   = rf;
    Wdata      = wd;
    if (v && push) sb.push_back('{dst, exp_en, kind, exp_rval, chk_rval});
    #2;
    guard = 0;
    while (mm_stall === 1'b1 && guard < 100) begin
      @(negedge clk);
      #2;
      guard++;
    end
    if (guard >= 100) begin
      checks++;
      errors++;
      $display("FAIL stall_bound: got stall beyond %0d cycles expected release", guard);
    end
    @(posedge clk);
  endtask

  task automatic bubbles(input int n);
    for (int k = 0; k < n; k++)
      issue(1'b0, OP_NONE, 1'b0, K_P, 5'd0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    ex_valid = 1'b0; ex_mem_op = OP_NONE; ex_wb_en = 1'b0; ex_wb_kind = K_P; ex_dst = 5'd0;
    result_P = 1'b0; result_I = 32'h0; result_F = 32'h0; Wdata = 32'h0;
    dmem_ack = 1'b0; dmem_rdata = 32'h0;
    repeat (3) @(negedge clk);
    #2;
    chk("rst_req", 32'(dmem_req), 32'h0);
    chk("rst_stall", 32'(mm_stall), 32'h0);
    chk("rst_wb_valid", 32'(wb_valid), 32'h0);
    chk("rst_mem_err", 32'(mem_err), 32'h0);
    chk("rst_rval_wb", rval_wb, 32'h0);
    chk("rst_rval_mm", rval_mm, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    // ALU ops of each kind
    issue(1'b1, OP_NONE, 1'b1, K_I, 5'd3, 1'b0, 32'h1234, 32'h0, 32'h0, 1'b1, 1'b1, 32'h1234, 1'b1);
    #1;
    chk("alu_rval_mm", rval_mm, 32'h1234);
    chk("alu_no_req", 32'(dmem_req), 32'h0);
    bubbles(2);
    chk("rval_wb_hold", rval_wb, 32'h1234);
    issue(1'b1, OP_NONE, 1'b1, K_P, 5'd4, 1'b1, 32'h55, 32'h66, 32'h0, 1'b1, 1'b1, 32'h1, 1'b1);
    #1;
    chk("alu_pval_mm", 32'(pval_mm), 32'h1);
    issue(1'b1, OP_NONE, 1'b1, K_F, 5'd6, 1'b0, 32'h8, 32'hCAFEF00D, 32'h0, 1'b1, 1'b1, 32'hCAFEF00D, 1'b1);
    #1;
    chk("alu_fval_mm", fval_mm, 32'hCAFEF00D);
    clear_counts();
    issue(1'b1, OP_RSVD, 1'b1, K_I, 5'd2, 1'b0, 32'h103, 32'h0, 32'h0, 1'b1, 1'b1, 32'h103, 1'b1);
    bubbles(2);
    chk("rsvd_no_req", 32'(req_cnt), 32'd0);
    chk("rsvd_no_err", 32'(mem_err), 32'h0);

    // Load acked after three wait cycles
    ack_lat = 3; rd_val = 32'hDEADBEEF;
    clear_counts();
    issue(1'b1, OP_LOAD, 1'b1, K_I, 5'd5, 1'b0, 32'h100, 32'h0, 32'h0, 1'b1, 1'b1, 32'hDEADBEEF, 1'b1);
    bubbles(2);
    chk("load_stall_cycles", 32'(stall_cnt), 32'd3);
    chk("load_req_cycles", 32'(req_cnt), 32'd4);
    chk("load_addr_stable", 32'(addr_bad), 32'd0);

    // Store with same-cycle ack
    ack_lat = 0;
    clear_counts();
    issue(1'b1, OP_STORE, 1'b1, K_I, 5'd7, 1'b0, 32'h40, 32'h0, 32'hA5A5A5A5, 1'b1, 1'b0, 32'h40, 1'b1);
    bubbles(2);
    chk("store_stall", 32'(stall_cnt), 32'd0);
    chk("store_req_cycles", 32'(req_cnt), 32'd1);
    chk("store_we", 32'(we_cnt), 32'd1);
    chk("store_wdata", last_wdata, 32'hA5A5A5A5);

    // Misaligned load
    clear_counts();
    issue(1'b1, OP_LOAD, 1'b1, K_I, 5'd8, 1'b0, 32'h102, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
    bubbles(2);
    chk("misalign_no_req", 32'(req_cnt), 32'd0);
    chk("misalign_err", 32'(mem_err), 32'h1);

    // Timeout (TIMEOUT=4): request held five cycles, then resume
    ack_lat = -1;
    clear_counts();
    issue(1'b1, OP_LOAD, 1'b1, K_I, 5'd9, 1'b0, 32'h200, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
    bubbles(2);
    chk("tmo_req_cycles", 32'(req_cnt), 32'd5);
    chk("tmo_stall_cycles", 32'(stall_cnt), 32'd4);
    issue(1'b1, OP_NONE, 1'b1, K_I, 5'd10, 1'b0, 32'h77, 32'h0, 32'h0, 1'b1, 1'b1, 32'h77, 1'b1);
    bubbles(2);
    chk("tmo_err_sticky", 32'(mem_err), 32'h1);

    // Ack arriving on the final allowed cycle succeeds
    ack_lat = 4; rd_val = 32'h11112222;
    clear_counts();
    issue(1'b1, OP_LOAD, 1'b1, K_I, 5'd11, 1'b0, 32'h204, 32'h0, 32'h0, 1'b1, 1'b1, 32'h11112222, 1'b1);
    bubbles(2);
    chk("lastack_req_cycles", 32'(req_cnt), 32'd5);
    chk("lastack_stall_cycles", 32'(stall_cnt), 32'd4);

    // Back-to-back zero-wait loads
    ack_lat = 0; rd_val = 32'h0BADF00D;
    clear_counts();
    issue(1'b1, OP_LOAD, 1'b1, K_I, 5'd12, 1'b0, 32'h300, 32'h0, 32'h0, 1'b1, 1'b1, 32'h0BADF00D, 1'b1);
    issue(1'b1, OP_LOAD, 1'b1, K_I, 5'd13, 1'b0, 32'h304, 32'h0, 32'h0, 1'b1, 1'b1, 32'h0BADF00D, 1'b1);
    bubbles(2);
    chk("b2b_req_cycles", 32'(req_cnt), 32'd2);
    chk("b2b_stall", 32'(stall_cnt), 32'd0);

    // Reset while waiting abandons the access
    ack_lat = -1;
    issue(1'b1, OP_LOAD, 1'b1, K_I, 5'd14, 1'b0, 32'h400, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    #2;
    chk("wait_req_before_rst", 32'(dmem_req), 32'h1);
    chk("wait_stall_before_rst", 32'(mm_stall), 32'h1);
    rst = 1'b0;
    ex_valid = 1'b0;
    #1;
    chk("rst_wait_req", 32'(dmem_req), 32'h0);
    chk("rst_wait_stall", 32'(mm_stall), 32'h0);
    chk("rst_wait_wb_valid", 32'(wb_valid), 32'h0);
    chk("rst_wait_mem_err", 32'(mem_err), 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    force_ack = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    chk("late_ack_no_req", 32'(dmem_req), 32'h0);
    force_ack = 1'b0;
    bubbles(3);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
